// File: rtl/servisia_mem_ctrl_if.sv
// servisia_mem_ctrl_if: Wishbone-classic word bus between the SERV core and the
// byte-wide external memory controller.
interface servisia_mem_ctrl_if;
    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_dat;
    logic [SEL_W-1:0] wb_sel;
    logic             wb_we;
    logic             wb_stb;
    logic [DAT_W-1:0] wb_rdt;
    logic             wb_ack;

    // Bus master (core side) drives the request and samples the response.
    modport master (
        output wb_adr, wb_dat, wb_sel, wb_we, wb_stb,
        input  wb_rdt, wb_ack
    );

    // Bus slave (memory controller side).
    modport slave (
        input  wb_adr, wb_dat, wb_sel, wb_we, wb_stb,
        output wb_rdt, wb_ack
    );
endinterface

// File: rtl/servisia_mem_ctrl.sv
// servisia_mem_ctrl: turns 32-bit Wishbone word requests into up to four 8-bit
// accesses on the external memory port (flash below 0x80000, SRAM at/above it).
// Optional build macro: SERVISIA_MEM_CTRL_SEL_SKIP_EN -- when defined, writes
// only spend cycles on bytes whose select bit is set.
module servisia_mem_ctrl (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    servisia_mem_ctrl_if.slave   wb,
    output logic                 read_o,
    output logic                 write_o,
    output logic [19:0]          addr_o,
    output logic [7:0]           wdata_o,
    input  logic [7:0]           rdata_i
);
    localparam int unsigned MEM_AW  = 20;
    localparam int unsigned WORD_AW = 18;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_AW-1:0] wadr_q, wadr_d;
    logic [WORD_W-1:0]  dat_q, dat_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               we_q, we_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic [BYTE_W-1:0]  wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic [WORD_W-1:0]  rdt_q, rdt_d;

    logic [IDX_W-1:0]   idx_next;
    logic [IDX_W-1:0]   idx_prev;

    // Address bits outside the word index inside the 1 MiB window are don't-care.
    logic unused_adr;
    assign unused_adr = ^{wb.wb_adr[31:20], wb.wb_adr[1:0]};

    // Select byte 'i' of a little-endian word.
    function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w,
                                                  input logic [IDX_W-1:0]  i);
        return w[{i, 3'b000} +: BYTE_W];
    endfunction

`ifdef SERVISIA_MEM_CTRL_SEL_SKIP_EN
    // Lowest set select bit at or above 'start'; result is {found, index}.
    function automatic logic [2:0] next_set(input logic [SEL_W-1:0] sel,
                                            input logic [2:0]       start);
        logic       found;
        logic [1:0] pos;
        found = 1'b0;
        pos   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && (3'(i) >= start) && sel[i]) begin
                found = 1'b1;
                pos   = 2'(i);
            end
        end
        return {found, pos};
    endfunction

    logic [2:0] nxt;
`endif

    assign idx_next = idx_q + 2'd1;
    assign idx_prev = idx_q - 2'd1;

    // Next-state and registered-output computation for the byte sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wadr_d  = wadr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdt_d   = rdt_q;
`ifdef SERVISIA_MEM_CTRL_SEL_SKIP_EN
        nxt     = 3'd0;
`endif

        case (state_q)
            S_IDLE: begin
                if (wb.wb_stb) begin
                    wadr_d = wb.wb_adr[19:2];
                    dat_d  = wb.wb_dat;
                    sel_d  = wb.wb_sel;
                    we_d   = wb.wb_we;
                    if (!wb.wb_we) begin
                        // Reads always fetch all four bytes starting at byte 0.
                        state_d = S_ACCESS;
                        idx_d   = 2'd0;
                        read_d  = 1'b1;
                        addr_d  = {wb.wb_adr[19:2], 2'd0};
                    end else begin
`ifdef SERVISIA_MEM_CTRL_SEL_SKIP_EN
                        nxt = next_set(wb.wb_sel, 3'd0);
                        if (nxt[2]) begin
                            state_d = S_ACCESS;
                            idx_d   = nxt[1:0];
                            write_d = 1'b1;
                            addr_d  = {wb.wb_adr[19:2], nxt[1:0]};
                            wdata_d = byte_of(wb.wb_dat, nxt[1:0]);
                        end else begin
                            // Nothing enabled: acknowledge straight away.
                            state_d = S_ACK;
                            ack_d   = 1'b1;
                        end
`else
                        state_d = S_ACCESS;
                        idx_d   = 2'd0;
                        write_d = wb.wb_sel[0];
                        addr_d  = {wb.wb_adr[19:2], 2'd0};
                        wdata_d = wb.wb_dat[7:0];
`endif
                    end
                end
            end

            S_ACCESS: begin
                if (!we_q) begin
                    // Byte issued last cycle is on rdata_i now.
                    if (idx_q != 2'd0) begin
                        rdt_d[{idx_prev, 3'b000} +: BYTE_W] = rdata_i;
                    end
                    if (idx_q == 2'd3) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d  = idx_next;
                        read_d = 1'b1;
                        addr_d = {wadr_q, idx_next};
                    end
                end else begin
`ifdef SERVISIA_MEM_CTRL_SEL_SKIP_EN
                    nxt = next_set(sel_q, {1'b0, idx_q} + 3'd1);
                    if (nxt[2]) begin
                        idx_d   = nxt[1:0];
                        write_d = 1'b1;
                        addr_d  = {wadr_q, nxt[1:0]};
                        wdata_d = byte_of(dat_q, nxt[1:0]);
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end
`else
                    if (idx_q == 2'd3) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                    end else begin
                        // Disabled bytes still take a cycle with the address stepping.
                        idx_d   = idx_next;
                        write_d = sel_q[idx_next];
                        addr_d  = {wadr_q, idx_next};
                        wdata_d = byte_of(dat_q, idx_next);
                    end
`endif
                end
            end

            S_DRAIN: begin
                rdt_d[31:24] = rdata_i;
                state_d      = S_ACK;
                ack_d        = 1'b1;
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wadr_q  <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wadr_q  <= wadr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdt_q   <= rdt_d;
        end
    end

    assign read_o    = read_q;
    assign write_o   = write_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign wb.wb_ack = ack_q;
    assign wb.wb_rdt = rdt_q;

endmodule

// File: tb/tb_servisia_mem_ctrl.sv
// Testbench for servisia_mem_ctrl: directed vector table plus reset,
// back-to-back and stb-drop sequences against a byte memory model.
module tb_servisia_mem_ctrl;

`ifdef SERVISIA_MEM_CTRL_SEL_SKIP_EN
    localparam int LAT_W_0101 = 3;
    localparam int LAT_W_0000 = 1;
`else
    localparam int LAT_W_0101 = 5;
    localparam int LAT_W_0000 = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read, write;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    servisia_mem_ctrl_if wb_if ();

    servisia_mem_ctrl dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wb      (wb_if),
        .read_o  (read),
        .write_o (write),
        .addr_o  (addr),
        .wdata_o (wdata),
        .rdata_i (rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] a;
        logic [7:0]  d;
    } wr_t;

    bit [7:0]    mem [bit [19:0]];
    wr_t         wr_log[$];
    logic [19:0] rd_log[$];
    int          ack_cnt = 0;
    int          overlap_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [7:0] init_byte(input logic [19:0] a);
        case (a)
            20'h12344: return 8'h11;
            20'h12345: return 8'h22;
            20'h12346: return 8'h33;
            20'h12347: return 8'h44;
            20'h80004: return 8'h55;
            20'h80005: return 8'h66;
            20'h80006: return 8'h77;
            20'h80007: return 8'h88;
            20'h80020: return 8'h01;
            20'h80021: return 8'h02;
            20'h80022: return 8'h03;
            20'h80023: return 8'h04;
            default:   return 8'h00;
        endcase
    endfunction

    // Byte memory: registered read data, writes logged.
    always @(posedge clk) begin
        if (read) begin
            rdata <= mem.exists(addr) ? mem[addr] : init_byte(addr);
            rd_log.push_back(addr);
        end
        if (write) begin
            mem[addr] = wdata;
            wr_log.push_back({addr, wdata});
        end
    end

    // Protocol monitor.
    always @(negedge clk) begin
        if (wb_if.wb_ack) ack_cnt++;
        if (read && write) overlap_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one request and count edges from acceptance to visible ack.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat);
        @(negedge clk);
        wb_if.wb_we  = we;
        wb_if.wb_adr = adr;
        wb_if.wb_dat = dat;
        wb_if.wb_sel = sel;
        wb_if.wb_stb = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wb_if.wb_ack) begin
                lat = n;
                break;
            end
        end
        wb_if.wb_stb = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(wb_if.wb_ack), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdt;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          lat;
        int          acks0;
        int          nexp;
        logic [19:0] ea;
        wr_t         ew;
        string       tag;

        vecs[0] = '{we: 1'b0, adr: 32'h0001_2344, dat: 32'h0,          sel: 4'h0, rdt: 32'h4433_2211, lat: 6};
        vecs[1] = '{we: 1'b1, adr: 32'h0008_0010, dat: 32'hDEAD_BEEF, sel: 4'hF, rdt: 32'h4433_2211, lat: 5};
        vecs[2] = '{we: 1'b0, adr: 32'h0008_0010, dat: 32'h0,          sel: 4'h0, rdt: 32'hDEAD_BEEF, lat: 6};
        vecs[3] = '{we: 1'b1, adr: 32'h0008_0020, dat: 32'hAABB_CCDD, sel: 4'h5, rdt: 32'hDEAD_BEEF, lat: LAT_W_0101};
        vecs[4] = '{we: 1'b0, adr: 32'h0008_0020, dat: 32'h0,          sel: 4'hF, rdt: 32'h04BB_02DD, lat: 6};
        vecs[5] = '{we: 1'b0, adr: 32'hFFF8_0004, dat: 32'h0,          sel: 4'h0, rdt: 32'h8877_6655, lat: 6};
        vecs[6] = '{we: 1'b1, adr: 32'h0008_0030, dat: 32'h1234_5678, sel: 4'h0, rdt: 32'h8877_6655, lat: LAT_W_0000};

        wb_if.wb_adr = '0;
        wb_if.wb_dat = '0;
        wb_if.wb_sel = '0;
        wb_if.wb_we  = 1'b0;
        wb_if.wb_stb = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_read",  32'(read),  32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_addr",  32'(addr),  32'd0);
        check("rst_ack",   32'(wb_if.wb_ack), 32'd0);
        check("rst_rdt",   wb_if.wb_rdt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Table-driven transactions.
        foreach (vecs[k]) begin
            rd_log.delete();
            wr_log.delete();
            acks0 = ack_cnt;
            run_txn(vecs[k].we, vecs[k].adr, vecs[k].dat, vecs[k].sel, lat);
            tag = $sformatf("v%0d", k);
            check({tag, "_lat"}, 32'(lat), 32'(vecs[k].lat));
            check({tag, "_rdt"}, wb_if.wb_rdt, vecs[k].rdt);
            check({tag, "_acks"}, 32'(ack_cnt - acks0), 32'd1);
            if (!vecs[k].we) begin
                check({tag, "_nrd"}, 32'(rd_log.size()), 32'd4);
                check({tag, "_nwr"}, 32'(wr_log.size()), 32'd0);
                for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
                    ea = {vecs[k].adr[19:2], 2'(i)};
                    check($sformatf("%s_rdaddr%0d", tag, i), 32'(rd_log[i]), 32'(ea));
                end
            end else begin
                nexp = 0;
                for (int i = 0; i < 4; i++) if (vecs[k].sel[i]) nexp++;
                check({tag, "_nwr"}, 32'(wr_log.size()), 32'(nexp));
                check({tag, "_nrd"}, 32'(rd_log.size()), 32'd0);
                nexp = 0;
                for (int i = 0; i < 4; i++) begin
                    if (vecs[k].sel[i]) begin
                        ew = {vecs[k].adr[19:2], 2'(i), vecs[k].dat[8*i +: 8]};
                        if (nexp < wr_log.size())
                            check($sformatf("%s_wr%0d", tag, i), 32'(wr_log[nexp]), 32'(ew));
                        nexp++;
                    end
                end
            end
        end

        // Reset in the middle of a read: outputs clear at once, no ack later.
        @(negedge clk);
        wb_if.wb_we  = 1'b0;
        wb_if.wb_adr = 32'h0001_2344;
        wb_if.wb_stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_read_active", 32'(read), 32'd1);
        acks0 = ack_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("async_read",  32'(read),  32'd0);
        check("async_write", 32'(write), 32'd0);
        check("async_addr",  32'(addr),  32'd0);
        check("async_wdata", 32'(wdata), 32'd0);
        check("async_ack",   32'(wb_if.wb_ack), 32'd0);
        check("async_rdt",   wb_if.wb_rdt, 32'd0);
        wb_if.wb_stb = 1'b0;
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(10);
        check("no_ack_dropped", 32'(ack_cnt - acks0), 32'd0);
        check("post_rst_read", 32'(read), 32'd0);
        run_txn(1'b0, 32'h0001_2344, 32'h0, 4'h0, lat);
        check("post_rst_lat", 32'(lat), 32'd6);
        check("post_rst_rdt", wb_if.wb_rdt, 32'h4433_2211);

        // Back-to-back write then read with stb held through the ack.
        rd_log.delete();
        wr_log.delete();
        acks0 = ack_cnt;
        @(negedge clk);
        wb_if.wb_we  = 1'b1;
        wb_if.wb_adr = 32'h0008_0040;
        wb_if.wb_dat = 32'h0102_0304;
        wb_if.wb_sel = 4'hF;
        wb_if.wb_stb = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wb_if.wb_ack) begin lat = n; break; end
        end
        check("b2b_wr_lat", 32'(lat), 32'd5);
        wb_if.wb_we = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wb_if.wb_ack) begin lat = n; break; end
        end
        wb_if.wb_stb = 1'b0;
        check("b2b_ack_gap", 32'(lat), 32'd7);
        idle_cycles(10);
        check("b2b_acks", 32'(ack_cnt - acks0), 32'd2);
        check("b2b_rdt", wb_if.wb_rdt, 32'h0102_0304);
        check("b2b_nwr", 32'(wr_log.size()), 32'd4);
        check("b2b_nrd", 32'(rd_log.size()), 32'd4);

        // stb dropped right after acceptance still completes with one ack.
        acks0 = ack_cnt;
        @(negedge clk);
        wb_if.wb_we  = 1'b0;
        wb_if.wb_adr = 32'h0008_0020;
        wb_if.wb_stb = 1'b1;
        @(posedge clk); #1;
        wb_if.wb_stb = 1'b0;
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wb_if.wb_ack) begin lat = n; break; end
        end
        check("drop_lat", 32'(lat), 32'd6);
        idle_cycles(10);
        check("drop_acks", 32'(ack_cnt - acks0), 32'd1);
        check("drop_rdt", wb_if.wb_rdt, 32'h04BB_02DD);

        check("no_rd_wr_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
